// File: rtl/ecc_58_scrub_ctrl.sv
// Background ECC scrubber: walks every RAM word in idle functional cycles,
// runs it through the external duplicated checker, writes back corrected
// data on single-bit errors and keeps saturating event counters.
//
// state  | meaning
// IDLE   | scrubbing disabled, nothing in flight
// WAIT   | interval down-counter running before the next word; leaves to IDLE
//        | if scrub_en drops before the word starts
// RD     | waiting for a free RAM cycle, then issue the scrub read
// CHK    | two cycles: capture returned word, then evaluate checker outputs
// WB     | waiting for a free RAM cycle to write corrected word back
module ecc_58_scrub_ctrl #(
  parameter int DATA_WIDTH   = 58,
  parameter int PARITY_WIDTH = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int DEPTH        = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scrub_en,
  input  logic [CNT_WIDTH-1:0]    scrub_interval,
  input  logic                    func_busy,
  input  logic                    func_wr_en,
  input  logic [ADDR_WIDTH-1:0]   func_wr_addr,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  input  logic [PARITY_WIDTH-1:0] mem_rd_parity,
  output logic [DATA_WIDTH-1:0]   ecc_data_in,
  output logic [PARITY_WIDTH-1:0] ecc_parity_in,
  input  logic [DATA_WIDTH-1:0]   ecc_data_out,
  input  logic                    ecc_sbit_err,
  input  logic                    ecc_dbit_err,
  input  logic                    ecc_fault,
  input  logic [PARITY_WIDTH-1:0] enc_parity,
  output logic                    mem_wr_en,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [PARITY_WIDTH-1:0] mem_wr_parity,
  output logic                    scrub_busy,
  output logic                    pass_done,
  output logic                    dbit_irq,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic [ADDR_WIDTH-1:0]   last_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_CHK,
    S_WB
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic                  chk_eval, chk_eval_nxt;
  logic [CNT_WIDTH-1:0]  wait_cnt;
  logic [ADDR_WIDTH-1:0] addr;

  logic wait_ld, wait_dec, wait_tc;
  logic capture, advance, wb_abort;
  logic ev_sbit, ev_dbit, ev_fault;

  // An interval of N gives N WAIT cycles, with a floor of one cycle for N=0.
  assign wait_tc  = (wait_cnt == '0) || (wait_cnt == CNT_WIDTH'(1));
  assign wb_abort = func_wr_en && (func_wr_addr == addr);

  assign mem_addr      = addr;
  assign mem_wr_parity = enc_parity;
  assign scrub_busy    = (state != S_IDLE);

  // State register and CHK phase flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      chk_eval <= 1'b0;
    end else begin
      state    <= state_nxt;
      chk_eval <= chk_eval_nxt;
    end
  end

  // Next-state decode, RAM strobes and per-word event classification.
  always_comb begin
    state_nxt    = state;
    chk_eval_nxt = 1'b0;
    wait_ld      = 1'b0;
    wait_dec     = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    ev_sbit      = 1'b0;
    ev_dbit      = 1'b0;
    ev_fault     = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (scrub_en) begin
          state_nxt = S_WAIT;
          wait_ld   = 1'b1;
        end
      end
      S_WAIT: begin
        if (!scrub_en) begin
          state_nxt = S_IDLE;
        end else if (wait_tc) begin
          state_nxt = S_RD;
        end else begin
          wait_dec = 1'b1;
        end
      end
      S_RD: begin
        if (!func_busy) begin
          mem_rd_en = 1'b1;
          state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (!chk_eval) begin
          capture      = 1'b1;
          chk_eval_nxt = 1'b1;
        end else if (ecc_fault) begin
          ev_fault = 1'b1;
          advance  = 1'b1;
        end else if (ecc_dbit_err) begin
          ev_dbit = 1'b1;
          advance = 1'b1;
        end else if (ecc_sbit_err) begin
          ev_sbit   = 1'b1;
          state_nxt = S_WB;
        end else begin
          advance = 1'b1;
        end
      end
      S_WB: begin
        // A functional write to the same word makes our correction stale.
        if (wb_abort) begin
          advance = 1'b1;
        end else if (!func_busy) begin
          mem_wr_en = 1'b1;
          advance   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (advance) begin
      state_nxt = scrub_en ? S_WAIT : S_IDLE;
      wait_ld   = scrub_en;
    end
  end

  // Datapath: interval timer, address walk, capture/write-back registers, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      addr          <= '0;
      ecc_data_in   <= '0;
      ecc_parity_in <= '0;
      mem_wr_data   <= '0;
      sbit_cnt      <= '0;
      dbit_cnt      <= '0;
      fault_cnt     <= '0;
      last_err_addr <= '0;
      pass_done     <= 1'b0;
      dbit_irq      <= 1'b0;
    end else begin
      if (wait_ld) begin
        wait_cnt <= scrub_interval;
      end else if (wait_dec) begin
        wait_cnt <= wait_cnt - CNT_WIDTH'(1);
      end
      if (capture) begin
        ecc_data_in   <= mem_rd_data;
        ecc_parity_in <= mem_rd_parity;
      end
      if (ev_sbit) begin
        mem_wr_data <= ecc_data_out;
      end
      if (ev_sbit && (sbit_cnt != '1)) begin
        sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      end
      if (ev_dbit && (dbit_cnt != '1)) begin
        dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
      end
      if (ev_fault && (fault_cnt != '1)) begin
        fault_cnt <= fault_cnt + CNT_WIDTH'(1);
      end
      if (ev_sbit || ev_dbit || ev_fault) begin
        last_err_addr <= addr;
      end
      dbit_irq  <= ev_dbit || ev_fault;
      pass_done <= advance && (addr == LAST_ADDR);
      if (advance) begin
        addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ecc_58_scrub_ctrl.sv
// Bench for ecc_58_scrub_ctrl: behavioural RAM, checker and encoder models,
// a table of single-pass error scenarios, hand-timed corner sequences and
// randomized passes compared against expected counts derived from the
// injected error map.
module tb_ecc_58_scrub_ctrl;
  localparam int DW = 58;
  localparam int PW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          scrub_en;
  logic [CW-1:0] scrub_interval;
  logic          func_busy;
  logic          func_wr_en;
  logic [AW-1:0] func_wr_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [PW-1:0] mem_rd_parity;
  logic [DW-1:0] ecc_data_in;
  logic [PW-1:0] ecc_parity_in;
  logic [DW-1:0] ecc_data_out;
  logic          ecc_sbit_err, ecc_dbit_err, ecc_fault;
  logic [PW-1:0] enc_parity;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [PW-1:0] mem_wr_parity;
  logic          scrub_busy, pass_done, dbit_irq;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [AW-1:0] last_err_addr;

  ecc_58_scrub_ctrl #(
    .DATA_WIDTH(DW), .PARITY_WIDTH(PW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
    .func_busy(func_busy), .func_wr_en(func_wr_en), .func_wr_addr(func_wr_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_parity(mem_rd_parity), .ecc_data_in(ecc_data_in), .ecc_parity_in(ecc_parity_in),
    .ecc_data_out(ecc_data_out), .ecc_sbit_err(ecc_sbit_err), .ecc_dbit_err(ecc_dbit_err),
    .ecc_fault(ecc_fault), .enc_parity(enc_parity), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_wr_parity(mem_wr_parity), .scrub_busy(scrub_busy),
    .pass_done(pass_done), .dbit_irq(dbit_irq), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .fault_cnt(fault_cnt), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  // Golden image: data per word, and injected error flags {fault, dbit, sbit}
  // stored in the low parity bits so the checker model sees them only
  // through the DUT's capture path.
  logic [DW-1:0] orig_d [DEPTH];
  logic [2:0]    orig_f [DEPTH];
  logic [DW-1:0] ram_d  [DEPTH];
  logic [PW-1:0] ram_p  [DEPTH];
  logic          load_req = 1'b0;
  logic          force_sbit = 1'b0;

  // RAM model: one-cycle read latency, write on strobe, bulk load from golden image.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_d[i] <= orig_d[i];
        ram_p[i] <= {5'b0, orig_f[i]};
      end
    end else begin
      if (mem_rd_en) begin
        mem_rd_data   <= ram_d[mem_addr];
        mem_rd_parity <= ram_p[mem_addr];
      end
      if (mem_wr_en) begin
        ram_d[mem_addr] <= mem_wr_data;
        ram_p[mem_addr] <= mem_wr_parity;
      end
    end
  end

  // Checker corrects by flipping bit 0; encoder yields clean flag bits.
  always_comb begin
    ecc_sbit_err = ecc_parity_in[0] | force_sbit;
    ecc_dbit_err = ecc_parity_in[1];
    ecc_fault    = ecc_parity_in[2];
    ecc_data_out = ecc_sbit_err ? (ecc_data_in ^ DW'(1)) : ecc_data_in;
  end
  assign enc_parity = {mem_wr_data[4:0], 3'b000};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt, wr_cnt, pd_cnt, irq_cnt, last_rd_cyc, first_gap;
  int inv_bad, rd_order_bad, pd_bad, wr_bad;

  // Bus monitor: strobe invariants, read order, write contents, pulse counts.
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0; wr_cnt = 0; pd_cnt = 0; irq_cnt = 0; last_rd_cyc = 0; first_gap = 0;
      inv_bad = 0; rd_order_bad = 0; pd_bad = 0; wr_bad = 0;
    end else begin
      if (mem_rd_en && mem_wr_en) inv_bad++;
      if (func_busy && (mem_rd_en || mem_wr_en)) inv_bad++;
      if (mem_rd_en) begin
        if (mem_addr != AW'(rd_cnt % DEPTH)) rd_order_bad++;
        if (rd_cnt == 1) first_gap = cyc - last_rd_cyc;
        last_rd_cyc = cyc;
        rd_cnt++;
      end
      if (mem_wr_en) begin
        if (!force_sbit) begin
          if (orig_f[mem_addr] != 3'b001) wr_bad++;
          if (mem_wr_data != (orig_d[mem_addr] ^ DW'(1))) wr_bad++;
          if (mem_wr_parity != {orig_d[mem_addr][4:1], ~orig_d[mem_addr][0], 3'b000}) wr_bad++;
        end
        wr_cnt++;
      end
      if (pass_done) begin
        pd_cnt++;
        if (rd_cnt != DEPTH * pd_cnt) pd_bad++;
      end
      if (dbit_irq) irq_cnt++;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_clean();
    logic [63:0] t;
    for (int i = 0; i < DEPTH; i++) begin
      t = {$urandom(), $urandom()};
      orig_d[i] = t[DW-1:0];
      orig_f[i] = 3'b000;
    end
  endtask

  // Reset the DUT and load the golden image into the RAM model.
  task automatic start(input int interval);
    load_req = 1'b1;
    rst = 1'b1; scrub_en = 1'b0; func_busy = 1'b0; func_wr_en = 1'b0; func_wr_addr = '0;
    scrub_interval = CW'(interval);
    repeat (2) @(posedge clk);
    #1;
    load_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(scrub_busy), 0);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 0);
    check({tag, "_wr_en"}, 64'(mem_wr_en), 0);
    check({tag, "_addr"}, 64'(mem_addr), 0);
    check({tag, "_pass_done"}, 64'(pass_done), 0);
    check({tag, "_irq"}, 64'(dbit_irq), 0);
    check({tag, "_sbit_cnt"}, 64'(sbit_cnt), 0);
    check({tag, "_dbit_cnt"}, 64'(dbit_cnt), 0);
    check({tag, "_fault_cnt"}, 64'(fault_cnt), 0);
    check({tag, "_last_err"}, 64'(last_err_addr), 0);
    check({tag, "_wr_data"}, 64'(mem_wr_data), 0);
    check({tag, "_ecc_data"}, 64'(ecc_data_in), 0);
  endtask

  // Scrub until n pass_done pulses, then stop and wait for IDLE.
  task automatic run_passes(input string tag, input int n, input int budget, input bit rand_busy);
    int seen;
    seen = 0;
    scrub_en = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pass_done) seen++;
      if (seen >= n) break;
      @(posedge clk);
      #1;
      if (rand_busy) func_busy = ($urandom_range(0, 9) < 3);
    end
    scrub_en = 1'b0;
    func_busy = 1'b0;
    check({tag, "_passes"}, 64'(seen), 64'(n));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!scrub_busy) break;
    end
    check({tag, "_stopped"}, 64'(scrub_busy), 0);
  endtask

  task automatic verify_pass(input string tag, input int e_sb, input int e_db, input int e_ft,
                             input int e_wr, input int e_irq, input int e_last);
    check({tag, "_sbit_cnt"}, 64'(sbit_cnt), 64'(e_sb));
    check({tag, "_dbit_cnt"}, 64'(dbit_cnt), 64'(e_db));
    check({tag, "_fault_cnt"}, 64'(fault_cnt), 64'(e_ft));
    check({tag, "_writes"}, 64'(wr_cnt), 64'(e_wr));
    check({tag, "_irqs"}, 64'(irq_cnt), 64'(e_irq));
    check({tag, "_last_err"}, 64'(last_err_addr), 64'(e_last));
    check({tag, "_reads"}, 64'(rd_cnt), 64'(DEPTH));
    check({tag, "_strobe_rules"}, 64'(inv_bad), 0);
    check({tag, "_read_order"}, 64'(rd_order_bad), 0);
    check({tag, "_pass_timing"}, 64'(pd_bad), 0);
    check({tag, "_wr_content"}, 64'(wr_bad), 0);
  endtask

  typedef struct {
    int       a0;
    logic [2:0] f0;
    int       a1;
    logic [2:0] f1;
    int       e_sb, e_db, e_ft, e_wr, e_irq, e_last;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_sb, e_db, e_ft, e_last;
    logic [2:0] f;

    // flags are {fault, dbit, sbit}; fault beats dbit beats sbit
    tbl[0] = '{5,  3'b001, 0,  3'b000, 1, 0, 0, 1, 0, 5};
    tbl[1] = '{9,  3'b010, 10, 3'b100, 0, 1, 1, 0, 2, 10};
    tbl[2] = '{0,  3'b011, 0,  3'b000, 0, 1, 0, 0, 1, 0};
    tbl[3] = '{63, 3'b101, 0,  3'b000, 0, 0, 1, 0, 1, 63};
    tbl[4] = '{62, 3'b111, 1,  3'b001, 1, 0, 1, 1, 1, 62};
    tbl[5] = '{20, 3'b110, 0,  3'b000, 0, 0, 1, 0, 1, 20};
    tbl[6] = '{0,  3'b000, 0,  3'b000, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{33, 3'b001, 34, 3'b001, 2, 0, 0, 2, 0, 34};

    fill_clean();
    start(0);
    @(negedge clk);
    check_reset_outputs("reset");

    // Table-driven single-pass scenarios, interval 0, functional port idle.
    for (int v = 0; v < 8; v++) begin
      fill_clean();
      orig_f[tbl[v].a0] = tbl[v].f0;
      if (tbl[v].f1 != 3'b000) orig_f[tbl[v].a1] = tbl[v].f1;
      start(0);
      run_passes($sformatf("vec%0d", v), 1, 800, 1'b0);
      verify_pass($sformatf("vec%0d", v), tbl[v].e_sb, tbl[v].e_db, tbl[v].e_ft,
                  tbl[v].e_wr, tbl[v].e_irq, tbl[v].e_last);
      check($sformatf("vec%0d_rd_spacing", v), 64'(first_gap), 4);
    end

    // Interval 10 with an sbit word at addr 1; drop scrub_en during its CHK.
    fill_clean();
    orig_f[1] = 3'b001;
    start(10);
    scrub_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (rd_cnt >= 2) break;
    end
    #1;
    scrub_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!scrub_busy) break;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("intv_rd_spacing", 64'(first_gap), 13);
    check("intv_reads", 64'(rd_cnt), 2);
    check("intv_wb_done", 64'(wr_cnt), 1);
    check("intv_wr_content", 64'(wr_bad), 0);
    check("intv_sbit_cnt", 64'(sbit_cnt), 1);
    check("intv_addr_adv", 64'(mem_addr), 2);
    check("intv_idle", 64'(scrub_busy), 0);

    // Write-back held by func_busy for 4 cycles, then aborted by a functional write.
    fill_clean();
    orig_f[3] = 3'b001;
    start(0);
    scrub_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (rd_cnt >= 4) break;
    end
    @(posedge clk);
    #1;
    func_busy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_hold_addr", 64'(mem_addr), 3);
    check("abort_hold_busy", 64'(scrub_busy), 1);
    func_wr_en = 1'b1;
    func_wr_addr = 6'd3;
    @(posedge clk);
    #1;
    func_wr_en = 1'b0;
    func_busy = 1'b0;
    run_passes("abort", 1, 800, 1'b0);
    verify_pass("abort", 1, 0, 0, 0, 0, 3);

    // Reset while a write-back is pending.
    fill_clean();
    orig_f[5] = 3'b001;
    start(0);
    scrub_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (rd_cnt >= 6) break;
    end
    @(posedge clk);
    #1;
    func_busy = 1'b1;
    @(posedge clk);
    #1;
    check("rstwb_addr", 64'(mem_addr), 5);
    check("rstwb_wr_data", 64'(mem_wr_data), 64'(orig_d[5] ^ DW'(1)));
    check("rstwb_sbit_cnt", 64'(sbit_cnt), 1);
    rst = 1'b1;
    scrub_en = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rstwb");
    rst = 1'b0;
    func_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rstwb_dropped", 64'(wr_cnt), 0);
    check("rstwb_idle", 64'(scrub_busy), 0);

    // Saturation: every word reports sbit for 5 passes (320 events, counter is 8 bits).
    fill_clean();
    force_sbit = 1'b1;
    start(0);
    run_passes("sat", 5, 3000, 1'b0);
    check("sat_sbit_cnt", 64'(sbit_cnt), 64'hFF);
    check("sat_dbit_cnt", 64'(dbit_cnt), 0);
    check("sat_writes", 64'(wr_cnt), 320);
    check("sat_strobe_rules", 64'(inv_bad), 0);
    force_sbit = 1'b0;

    // Randomized error maps, intervals and functional-port contention.
    for (int it = 0; it < 6; it++) begin
      fill_clean();
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 15) >= 10) orig_f[i] = 3'($urandom_range(1, 7));
      end
      e_sb = 0; e_db = 0; e_ft = 0; e_last = 0;
      for (int i = 0; i < DEPTH; i++) begin
        f = orig_f[i];
        if (f[2]) e_ft++;
        else if (f[1]) e_db++;
        else if (f[0]) e_sb++;
        if (f != 3'b000) e_last = i;
      end
      start($urandom_range(0, 3));
      run_passes($sformatf("rnd%0d", it), 1, 4000, 1'b1);
      verify_pass($sformatf("rnd%0d", it), e_sb, e_db, e_ft, e_sb, e_db + e_ft, e_last);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ecc_58_scrub_ctrl.md
Name: ecc_58_scrub_ctrl

Overview:
- Background scrubber for a DEPTH-entry FIFO RAM whose words are 58 data + 8 parity bits.
- Walks the RAM address by address and reads each word during cycles the functional port leaves free.
- Sends each word through the duplicated-checker ECC fault-detection datapath (external instance).
- Writes back corrected data, re-encoded by an external ECC encoder, on single-bit errors; counts sbit/dbit/checker-fault events for status.

Parameters:
- DATA_WIDTH, 58, data bits per word
- PARITY_WIDTH, 8, ECC parity bits per word
- ADDR_WIDTH, 6, RAM address width
- DEPTH, 64, number of RAM entries (<= 2**ADDR_WIDTH)
- CNT_WIDTH, 16, width of error counters and interval

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- scrub_en  in  1  enable scrubbing
- scrub_interval  in  CNT_WIDTH  idle cycles between word scrubs; 0 = back-to-back
- func_busy  in  1  functional port owns RAM this cycle; scrubber must not issue
- func_wr_en  in  1  functional write strobe
- func_wr_addr  in  ADDR_WIDTH  functional write address
- mem_rd_en  out  1  scrub read strobe; RAM data returns next cycle
- mem_addr  out  ADDR_WIDTH  scrub read/write address
- mem_rd_data  in  DATA_WIDTH  returned data
- mem_rd_parity  in  PARITY_WIDTH  returned parity
- ecc_data_in  out  DATA_WIDTH  to checker data_in (registered RAM data)
- ecc_parity_in  out  PARITY_WIDTH  to checker parity_in
- ecc_data_out  in  DATA_WIDTH  checker corrected data
- ecc_sbit_err  in  1  checker single-bit error
- ecc_dbit_err  in  1  checker double-bit error
- ecc_fault  in  1  checker redundancy mismatch
- enc_parity  in  PARITY_WIDTH  encoder parity of mem_wr_data (combinational)
- mem_wr_en  out  1  scrub write-back strobe
- mem_wr_data  out  DATA_WIDTH  corrected data
- mem_wr_parity  out  PARITY_WIDTH  = enc_parity
- scrub_busy  out  1  high in any state except IDLE
- pass_done  out  1  one-cycle pulse after the last address of a pass
- dbit_irq  out  1  one-cycle pulse on an uncorrectable word or checker fault
- sbit_cnt, dbit_cnt, fault_cnt  out  CNT_WIDTH each  saturating event counters
- last_err_addr  out  ADDR_WIDTH  address of the most recent sbit/dbit/fault event

Behaviour:
- Reset: state IDLE, address 0, interval counter 0, all counters 0, last_err_addr 0, all strobes/pulses 0, scrub_busy 0.
- States: IDLE, WAIT, RD, CHK, WB.
  - IDLE: on scrub_en=1, go to WAIT and load the interval counter with scrub_interval.
  - WAIT: decrement each cycle; at 0 go to RD. With scrub_interval=0, WAIT lasts 1 cycle.
  - RD: if func_busy=0, assert mem_rd_en for 1 cycle and go to CHK. Otherwise hold in RD with no strobe.
  - CHK: register mem_rd_data/parity into ecc_data_in/parity_in, then evaluate the checker outputs one cycle later (2-cycle CHK: capture, evaluate).
- Evaluate, with priority fault > dbit > sbit:
  - ecc_fault=1: fault_cnt++, dbit_irq pulse, no write-back.
  - else ecc_dbit_err=1: dbit_cnt++, dbit_irq pulse, no write-back.
  - else ecc_sbit_err=1: sbit_cnt++, latch ecc_data_out into mem_wr_data, go to WB.
  - else clean: advance.
  - Any event updates last_err_addr.
- WB: if func_busy=0, assert mem_wr_en for 1 cycle, then advance. While waiting, a func_wr_en with func_wr_addr == mem_addr aborts the write-back (sbit_cnt already counted) and advances.
- Advance: address+1; at DEPTH-1 wrap to 0 and pulse pass_done. Then go to WAIT if scrub_en=1, else IDLE.
- scrub_en deassert mid-word: the current word completes (including WB); no new word starts.
- Counters saturate at all-ones.
- rst mid-operation: return to the reset state immediately; any pending write-back is dropped.
- mem_rd_en and mem_wr_en are never both asserted; neither is asserted while func_busy=1.

Test Plan:
- Clean RAM, DEPTH=64, interval=0, func_busy=0 -> 64 reads, 0 writes, pass_done after the 64th word, all counters 0.
- Single-bit flip at addr 5, checker reports sbit -> one write at addr 5 with corrected data and enc_parity, sbit_cnt=1, last_err_addr=5.
- dbit at addr 9, then ecc_fault at addr 10 -> no writes, dbit_cnt=1, fault_cnt=1, two dbit_irq pulses, last_err_addr=10.
- sbit at addr 3 with func_busy held 4 cycles in WB, plus func_wr_en to addr 3 -> write-back aborted, mem_wr_en never high, sbit_cnt=1.
- interval=10 -> exactly 10 WAIT cycles between consecutive mem_rd_en pulses; drop scrub_en during CHK -> word finishes, then IDLE, scrub_busy=0.
- rst asserted in WB -> next cycle all outputs at reset values; sbit_cnt forced to all-ones plus one more sbit -> stays all-ones.
